// File: rtl/ram_responder_pkg.sv
// Shared state encoding, latency limit and parity helper for ram_responder.
// The parity helper is used when RAM_PARITY_EN is defined; benches and BIST may reuse it.
package ram_responder_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_READ  = 2'd2
   } state_e;

   localparam int RD_LAT_MAX = 4;
   localparam int CNT_W      = $clog2(RD_LAT_MAX);

   function automatic logic even_parity(input logic [63:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/ram_array.sv
// Word storage with one write port and one registered read port.
// With RAM_PARITY_EN defined each word carries an even-parity bit and rd_perr reports mismatches.
module ram_array
   import ram_responder_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             res,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
`ifdef RAM_PARITY_EN
   output logic             rd_perr,
`endif
   output logic [WIDTH-1:0] rd_data
);

`ifdef RAM_PARITY_EN
   localparam int SW = WIDTH + 1;
`else
   localparam int SW = WIDTH;
`endif

   logic [SW-1:0]    mem_q [DEPTH];
   logic [SW-1:0]    wr_word;
   logic [SW-1:0]    rd_word;
   logic [WIDTH-1:0] rd_data_d, rd_data_q;
`ifdef RAM_PARITY_EN
   logic             rd_perr_d, rd_perr_q;
`endif

   // Out-of-range reads (non-power-of-2 DEPTH) see an all-zero word, so parity also reads clean.
   always_comb begin
`ifdef RAM_PARITY_EN
      wr_word = {even_parity(64'(wr_data)), wr_data};
`else
      wr_word = wr_data;
`endif
      rd_word   = (int'(rd_addr) < DEPTH) ? mem_q[rd_addr] : '0;
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = rd_word[WIDTH-1:0];
`ifdef RAM_PARITY_EN
      rd_perr_d = rd_perr_q;
      if (rd_en) rd_perr_d = rd_word[WIDTH] ^ even_parity(64'(rd_word[WIDTH-1:0]));
`endif
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_word;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         rd_data_q <= '0;
`ifdef RAM_PARITY_EN
         rd_perr_q <= 1'b0;
`endif
      end else begin
         rd_data_q <= rd_data_d;
`ifdef RAM_PARITY_EN
         rd_perr_q <= rd_perr_d;
`endif
      end
   end

   assign rd_data = rd_data_q;
`ifdef RAM_PARITY_EN
   assign rd_perr = rd_perr_q;
`endif

endmodule

// File: rtl/ram_responder.sv
// Request/done RAM responder: post-reset clear sweep, write/read handling and RD_LAT read latency.
// Optional parity checking is enabled with the RAM_PARITY_EN macro (adds the perr port).
module ram_responder
   import ram_responder_pkg::*;
#(
   parameter  int WIDTH  = 4,
   parameter  int DEPTH  = 8,
   parameter  int RD_LAT = 1,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             res,
   input  logic             wen,
   input  logic             ren,
   input  logic [AW-1:0]    address,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] Q,
`ifdef RAM_PARITY_EN
   output logic             perr,
`endif
   output logic             done,
   output logic             busy
);

   state_e           state_d, state_q;
   logic [AW-1:0]    ptr_d, ptr_q;
   logic [AW-1:0]    addr_d, addr_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             done_d, done_q;
   logic             busy_d, busy_q;

   logic             wr_req, rd_req;
   logic [AW-1:0]    wr_addr, rd_addr;
   logic [WIDTH-1:0] wr_data;
   logic             addr_ok;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      wr_req  = 1'b0;
      wr_addr = address;
      wr_data = data;
      rd_req  = 1'b0;
      rd_addr = address;
      addr_ok = int'(address) < DEPTH;
      case (state_q)
         ST_CLEAR: begin
            wr_req  = 1'b1;
            wr_addr = ptr_q;
            wr_data = '0;
            if (ptr_q == AW'(DEPTH - 1)) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (wen) begin
               wr_req = addr_ok;
               done_d = 1'b1;
            end else if (ren) begin
               addr_d = address;
               if (RD_LAT == 1) begin
                  rd_req = 1'b1;
                  done_d = 1'b1;
               end else begin
                  state_d = ST_READ;
                  busy_d  = 1'b1;
                  cnt_d   = CNT_W'(RD_LAT - 2);
               end
            end
         end
         ST_READ: begin
            // Counter expires on the edge that loads Q, done rises with it.
            if (cnt_q == '0) begin
               rd_req  = 1'b1;
               rd_addr = addr_q;
               done_d  = 1'b1;
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
            busy_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   ram_array #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_array (
      .clk     (clk),
      .res     (res),
      .wr_en   (wr_req & ~res),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_req & ~res),
      .rd_addr (rd_addr),
`ifdef RAM_PARITY_EN
      .rd_perr (perr),
`endif
      .rd_data (Q)
   );

   assign done = done_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: an RD_LAT=2 instance plus an RD_LAT=1 instance.
// Parity checks are compiled in when RAM_PARITY_EN is defined.
module tb_ram_responder;

   localparam int WIDTH = 4;
   localparam int DEPTH = 8;
   localparam int LAT   = 2;

   logic       clk = 1'b0;
   logic       res, wen, ren;
   logic [2:0] address;
   logic [3:0] data, q;
   logic       done, busy;
   logic       res1, wen1, ren1;
   logic [2:0] address1;
   logic [3:0] data1, q1;
   logic       done1, busy1;
`ifdef RAM_PARITY_EN
   logic       perr, perr1;
`endif

   int         checks = 0;
   int         passed = 0;
   logic [3:0] refMem  [DEPTH];
   logic [3:0] refMem1 [DEPTH];
   logic       refBad  [DEPTH];
   logic [3:0] refQ;

   always #5 clk = ~clk;

   ram_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(LAT)) dut (
      .clk     (clk),
      .res     (res),
      .wen     (wen),
      .ren     (ren),
      .address (address),
      .data    (data),
      .Q       (q),
`ifdef RAM_PARITY_EN
      .perr    (perr),
`endif
      .done    (done),
      .busy    (busy)
   );

   ram_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(1)) dut1 (
      .clk     (clk),
      .res     (res1),
      .wen     (wen1),
      .ren     (ren1),
      .address (address1),
      .data    (data1),
      .Q       (q1),
`ifdef RAM_PARITY_EN
      .perr    (perr1),
`endif
      .done    (done1),
      .busy    (busy1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Holds reset, then counts busy cycles while hammering ignored writes during the clear.
   task automatic resetMain(input int cycles);
      int busyCycles;
      logic sawDone;
      res = 1'b1; wen = 1'b0; ren = 1'b0;
      repeat (cycles) @(negedge clk);
      checkOutput("rstQ", q, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstBusy", busy, 1);
`ifdef RAM_PARITY_EN
      checkOutput("rstPerr", perr, 0);
`endif
      refQ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         refMem[i] = '0;
         refBad[i] = 1'b0;
      end
      res = 1'b0; wen = 1'b1; address = 3'd0; data = 4'hF;
      busyCycles = 1;
      sawDone = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) sawDone = 1'b1;
         if (!busy) break;
         busyCycles++;
      end
      wen = 1'b0;
      checkOutput("clearLen", busyCycles, DEPTH);
      checkOutput("clearDone", sawDone, 0);
   endtask

   task automatic writeWord(input logic [2:0] a, input logic [3:0] d, input bit idleAfter);
      wen = 1'b1; ren = 1'b0; address = a; data = d;
      @(negedge clk);
      wen = 1'b0;
      refMem[a] = d;
      refBad[a] = 1'b0;
      checkOutput("wrDone", done, 1);
      checkOutput("wrBusy", busy, 0);
      if (idleAfter) begin
         @(negedge clk);
         checkOutput("wrPulse", done, 0);
      end
   endtask

   task automatic readWord(input logic [2:0] a);
      ren = 1'b1; wen = 1'b0; address = a;
      @(negedge clk);
      ren = 1'b0;
      for (int i = 1; i < LAT; i++) begin
         checkOutput("rdBusy", busy, 1);
         checkOutput("rdEarly", done, 0);
         checkOutput("rdQHold", q, refQ);
         @(negedge clk);
      end
      refQ = refMem[a];
      checkOutput("rdDone", done, 1);
      checkOutput("rdQ", q, refQ);
      checkOutput("rdIdle", busy, 0);
`ifdef RAM_PARITY_EN
      checkOutput("rdPerr", perr, refBad[a]);
`endif
      @(negedge clk);
      checkOutput("rdPulse", done, 0);
      checkOutput("rdQKeep", q, refQ);
   endtask

   task automatic applyStimulus(input logic [2:0] a, input logic [3:0] d);
      wen = 1'b1; ren = 1'b1; address = a; data = d;
      @(negedge clk);
      wen = 1'b0; ren = 1'b0;
      refMem[a] = d;
      refBad[a] = 1'b0;
      checkOutput("bothDone", done, 1);
      checkOutput("bothBusy", busy, 0);
      checkOutput("bothQ", q, refQ);
      @(negedge clk);
      checkOutput("bothPulse", done, 0);
   endtask

   initial begin
      int n;
      logic [3:0] walk [5];
      walk[0] = 4'h1; walk[1] = 4'h2; walk[2] = 4'h4; walk[3] = 4'h8; walk[4] = 4'hF;
      res = 1'b1; wen = 1'b0; ren = 1'b0; address = '0; data = '0;
      res1 = 1'b1; wen1 = 1'b0; ren1 = 1'b0; address1 = '0; data1 = '0;
      refQ = '0;

      resetMain(2);
      for (int i = 0; i < DEPTH; i++) readWord(3'(i));

      writeWord(3'd3, 4'hA, 1'b1);
      readWord(3'd3);

      for (int i = 0; i < DEPTH; i++) begin
         for (int v = 0; v < 5; v++) begin
            writeWord(3'(i), walk[v], 1'b0);
            for (int j = 0; j < DEPTH; j++) readWord(3'(j));
         end
      end
      for (int i = 0; i < DEPTH; i++) writeWord(3'(i), 4'(DEPTH - 1 - i), 1'b0);
      for (int i = 0; i < DEPTH; i++) readWord(3'(i));

      applyStimulus(3'd2, 4'h5);
      readWord(3'd2);

      // A second read request during READ must be dropped.
      ren = 1'b1; address = 3'd4;
      @(negedge clk);
      checkOutput("ignBusy", busy, 1);
      address = 3'd5;
      @(negedge clk);
      ren = 1'b0;
      refQ = refMem[4];
      checkOutput("ignDone", done, 1);
      checkOutput("ignQ", q, refQ);
      @(negedge clk);
      checkOutput("ignPulse", done, 0);
      checkOutput("ignIdle", busy, 0);

      ren = 1'b1; address = 3'd3;
      @(negedge clk);
      checkOutput("abortBusy", busy, 1);
      ren = 1'b0;
      resetMain(1);
      readWord(3'd3);

      writeWord(3'd6, 4'h9, 1'b0);
      readWord(3'd6);

      for (int it = 0; it < 150; it++) begin
         logic [2:0] a;
         logic [3:0] d;
         a = 3'($urandom_range(0, DEPTH - 1));
         d = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0, 1:    writeWord(a, d, 1'($urandom_range(0, 1)));
            2:       readWord(a);
            default: applyStimulus(a, d);
         endcase
      end

`ifdef RAM_PARITY_EN
      writeWord(3'd1, 4'h3, 1'b1);
      dut.u_array.mem_q[1][0] = ~dut.u_array.mem_q[1][0];
      refMem[1] = 4'h2;
      refBad[1] = 1'b1;
      readWord(3'd1);
      readWord(3'd0);
`endif

      res1 = 1'b1;
      repeat (2) @(negedge clk);
      res1 = 1'b0;
      n = 0;
      while (busy1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("lat1Clear", n, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         refMem1[i] = 4'($urandom_range(0, 15));
         wen1 = 1'b1; address1 = 3'(i); data1 = refMem1[i];
         @(negedge clk);
         checkOutput("lat1WrDone", done1, 1);
      end
      wen1 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ren1 = 1'b1; address1 = 3'(i);
         @(negedge clk);
         checkOutput("lat1Q", q1, refMem1[i]);
         checkOutput("lat1Done", done1, 1);
         checkOutput("lat1Busy", busy1, 0);
      end
      ren1 = 1'b0;
      @(negedge clk);
      checkOutput("lat1Pulse", done1, 0);
      checkOutput("lat1QKeep", q1, refMem1[DEPTH-1]);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
